// File: rtl/stream_demux4_pkg.sv
// Shared constants and helpers for the 4-way stream demultiplexer.
package stream_demux4_pkg;
  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return NUM_CH'(1) << sel;
  endfunction
endpackage

// File: rtl/stream_slot.sv
// Single-entry output slot: valid/data register with load/drain and a wrapping
// delivered-word counter.
module stream_slot #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] xfer_cnt
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain;

  always_comb begin
    drain   = valid_q & out_ready;
    // A load on the same edge as a drain keeps the slot full with the new word.
    valid_d = load | (valid_q & ~drain);
    data_d  = load ? load_data : data_q;
    cnt_d   = drain ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign xfer_cnt  = cnt_q;
endmodule

// File: rtl/stream_demux4.sv
// 1-to-4 stream demultiplexer: steers each accepted word into the slot picked by
// in_sel; each slot stalls independently.
module stream_demux4
  import stream_demux4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic [WIDTH-1:0]    in_data,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready,
  output logic [WIDTH-1:0]    out_data0,
  output logic [WIDTH-1:0]    out_data1,
  output logic [WIDTH-1:0]    out_data2,
  output logic [WIDTH-1:0]    out_data3,
  output logic [CNT_W-1:0]    xfer_cnt0,
  output logic [CNT_W-1:0]    xfer_cnt1,
  output logic [CNT_W-1:0]    xfer_cnt2,
  output logic [CNT_W-1:0]    xfer_cnt3,
  output logic                busy
);
  logic [NUM_CH-1:0]             load;
  logic [NUM_CH-1:0][WIDTH-1:0]  data_arr;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_arr;

  // Ready looks only at the targeted slot so a stalled channel blocks nothing else.
  assign in_ready = !out_valid[in_sel] | out_ready[in_sel];
  assign load     = (in_valid & in_ready) ? sel_onehot(in_sel) : '0;
  assign busy     = |out_valid;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    stream_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (data_arr[k]),
      .xfer_cnt  (cnt_arr[k])
    );
  end

  assign out_data0 = data_arr[0];
  assign out_data1 = data_arr[1];
  assign out_data2 = data_arr[2];
  assign out_data3 = data_arr[3];
  assign xfer_cnt0 = cnt_arr[0];
  assign xfer_cnt1 = cnt_arr[1];
  assign xfer_cnt2 = cnt_arr[2];
  assign xfer_cnt3 = cnt_arr[3];
endmodule
